// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive CDC, FWFT byte FIFO, overflow flag and idle-line timeout
module uart_rx_buffer #(
    parameter int P_DEPTH = 16,
    parameter int P_LW    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_flush,
    input  logic              i_clr_overflow,
    input  logic [23:0]       i_timeout_cycles,
    output logic [7:0]        o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [P_LW-1:0]   o_level,
    output logic              o_overflow,
    output logic              o_idle_timeout
);

    localparam int AW = P_LW - 1;
    localparam logic [P_LW-1:0] PTR_ONE = 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic s1, s2, s3;
    // primed/rx_armed make sure a level already high when reset releases is not
    // taken as a fresh byte: the line must be seen low once before edges count.
    logic primed, rx_armed;
    logic push_evt;

    logic [P_LW-1:0] wr_ptr, rd_ptr;
    logic [7:0]      mem [P_DEPTH];
    logic            full, empty, pop, push_ok, ovf_set;

    logic [0:0]  state;
    logic [23:0] cnt;

    // Two-flop synchronizer plus edge-detect delay flop, with the post-reset low-line qualifier
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            primed   <= 1'b0;
            rx_armed <= 1'b0;
        end else begin
            s1     <= i_rx_valid;
            s2     <= s1;
            s3     <= s2;
            primed <= 1'b1;
            if (primed && !s1)
                rx_armed <= 1'b1;
        end
    end

    assign push_evt = s2 & ~s3 & rx_armed;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop     = ~empty & i_ready & ~i_flush;
    // A pop on a full FIFO frees the slot the incoming byte lands in.
    assign push_ok = push_evt & ~i_flush & (~full | pop);
    assign ovf_set = push_evt & ~i_flush & full & ~pop;

    // Read/write pointers; flush returns both to zero and overrides push/pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Byte storage, intentionally not reset
    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= i_rx_data;
    end

    assign o_data  = mem[rd_ptr[AW-1:0]];
    assign o_valid = ~empty;
    assign o_level = wr_ptr - rd_ptr;

    // Sticky overflow; a new drop in the clear cycle keeps the flag set
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            o_overflow <= 1'b0;
        else if (ovf_set)
            o_overflow <= 1'b1;
        else if (i_clr_overflow)
            o_overflow <= 1'b0;
    end

    // Idle-line timer: armed by any byte edge, pulses after i_timeout_cycles quiet cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            o_idle_timeout <= 1'b0;
        end else begin
            o_idle_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (push_evt && (i_timeout_cycles != 24'd0)) begin
                        state <= ST_ARMED;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (i_timeout_cycles == 24'd0) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (push_evt) begin
                        cnt <= '0;
                    end else if (cnt == (i_timeout_cycles - 24'd1)) begin
                        o_idle_timeout <= 1'b1;
                        state          <= ST_IDLE;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - directed self-checking bench for uart_rx_buffer
module tb_uart_rx_buffer;

    logic        clock;
    logic        reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_flush;
    logic        i_clr_overflow;
    logic [23:0] i_timeout_cycles;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_level;
    logic        o_overflow;
    logic        o_idle_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int pops  = 0;
    int npulse;
    int pk;
    logic [7:0] basic [3];
    logic [7:0] expb;

    uart_rx_buffer #(.P_DEPTH(16), .P_LW(5)) dut (
        .clock            (clock),
        .reset            (reset),
        .i_rx_data        (i_rx_data),
        .i_rx_valid       (i_rx_valid),
        .i_flush          (i_flush),
        .i_clr_overflow   (i_clr_overflow),
        .i_timeout_cycles (i_timeout_cycles),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_level          (o_level),
        .o_overflow       (o_overflow),
        .o_idle_timeout   (o_idle_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pop counter
    always @(posedge clock) begin
        if (!reset && o_valid && i_ready)
            pops <= pops + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        i_rx_data  = d;
        i_rx_valid = 1'b1;
        repeat (3) tick();
        i_rx_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        basic[0] = 8'h55;
        basic[1] = 8'hA3;
        basic[2] = 8'h00;
        reset = 1'b1;
        i_rx_data = 8'h00;
        i_rx_valid = 1'b0;
        i_flush = 1'b0;
        i_clr_overflow = 1'b0;
        i_timeout_cycles = 24'd0;
        i_ready = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_tmo", o_idle_timeout, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        tick();

        // Basic receive, consumer always ready
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_rx_data  = basic[i];
            i_rx_valid = 1'b1;
            tick();
            tick();
            chk("basic_early", o_valid, 0);
            tick();
            chk("basic_valid", o_valid, 1);
            chk("basic_data", o_data, basic[i]);
            chk("basic_level1", o_level, 1);
            tick();
            chk("basic_popped", o_valid, 0);
            repeat (4) tick();
            i_rx_valid = 1'b0;
            repeat (8) tick();
            chk("basic_level0", o_level, 0);
        end
        chk("basic_pops", pops, 3);

        // Fill and overflow
        i_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("fill_level16", o_level, 16);
        chk("fill_no_ovf", o_overflow, 0);
        send(8'h10);
        chk("ovf_level16", o_level, 16);
        chk("ovf_set", o_overflow, 1);
        i_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", o_valid, 1);
            chk("drain_data", o_data, i);
            tick();
        end
        i_ready = 1'b0;
        chk("drain_empty", o_valid, 0);
        chk("ovf_sticky", o_overflow, 1);

        // Flush coincident with a push event, overflow still set
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i));
        chk("flush_pre_level", o_level, 5);
        i_rx_data  = 8'h65;
        i_rx_valid = 1'b1;
        tick();
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_level", o_level, 0);
        chk("flush_valid", o_valid, 0);
        chk("flush_ovf_kept", o_overflow, 1);
        tick();
        i_rx_valid = 1'b0;
        repeat (3) tick();
        chk("flush_byte_lost", o_level, 0);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        chk("ovf_cleared", o_overflow, 0);

        // Full FIFO, push event in the same cycle as a pop
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
        chk("fp_level_pre", o_level, 16);
        i_rx_data  = 8'hEE;
        i_rx_valid = 1'b1;
        tick();
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("fp_level", o_level, 16);
        chk("fp_no_ovf", o_overflow, 0);
        chk("fp_head", o_data, 8'h21);
        i_rx_valid = 1'b0;
        repeat (3) tick();
        i_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expb = (i < 15) ? (8'h21 + 8'(i)) : 8'hEE;
            chk("fp_drain", o_data, expb);
            tick();
        end
        chk("fp_level0", o_level, 0);

        // Idle timeout, single byte
        i_timeout_cycles = 24'd100;
        i_rx_data  = 8'h11;
        i_rx_valid = 1'b1;
        repeat (3) tick();
        i_rx_valid = 1'b0;
        npulse = 0;
        pk = 0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (o_idle_timeout) begin
                npulse++;
                pk = k;
            end
        end
        chk("tmo_count", npulse, 1);
        chk("tmo_at", pk, 100);

        // Second byte 50 cycles later pushes the pulse out
        i_rx_data  = 8'h22;
        i_rx_valid = 1'b1;
        repeat (3) tick();
        i_rx_valid = 1'b0;
        npulse = 0;
        pk = 0;
        for (int k = 1; k <= 170; k++) begin
            tick();
            if (o_idle_timeout) begin
                npulse++;
                pk = k;
            end
            if (k == 47) begin
                i_rx_data  = 8'h33;
                i_rx_valid = 1'b1;
            end
            if (k == 50) i_rx_valid = 1'b0;
        end
        chk("tmo2_count", npulse, 1);
        chk("tmo2_at", pk, 150);

        // Timeout disabled
        i_timeout_cycles = 24'd0;
        send(8'h44);
        npulse = 0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (o_idle_timeout) npulse++;
        end
        chk("tmo_off", npulse, 0);
        chk("tmo_off_level", o_level, 0);

        // Mid-stream reset with a level held high
        i_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("mrst_pre_level", o_level, 3);
        i_rx_data  = 8'h99;
        i_rx_valid = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        chk("mrst_valid", o_valid, 0);
        chk("mrst_level", o_level, 0);
        chk("mrst_ovf", o_overflow, 0);
        chk("mrst_tmo", o_idle_timeout, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("mrst_held_level", o_level, 0);
        chk("mrst_held_valid", o_valid, 0);
        i_rx_valid = 1'b0;
        repeat (4) tick();
        send(8'h7E);
        chk("mrst_fresh_level", o_level, 1);
        chk("mrst_fresh_data", o_data, 8'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
